// File: rtl/gene_stripe_feeder.sv
// Stripe feeder for the gene alignment PE array: holds genes A and B,
// loads one B stripe per pass, streams A and collects per-stripe results.
module gene_stripe_feeder #(
  parameter int N_PE     = 64,
  parameter int SEQ_LEN  = 1024,
  parameter int N_STRIPE = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_load_we,
  input  logic                        i_load_sel,
  input  logic [$clog2(SEQ_LEN)-1:0]  i_load_addr,
  input  logic [1:0]                  i_load_data,
  input  logic                        i_go,
  input  logic                        i_stripe_end,
  input  logic [$clog2(SEQ_LEN)-1:0]  i_start_position,
  input  logic [$clog2(SEQ_LEN)-1:0]  i_end_position,
  input  logic [13:0]                 i_max_score_stripe,
  output logic [2*N_PE-1:0]           o_B,
  output logic [1:0]                  o_A,
  output logic                        o_start,
  output logic                        o_busy,
  output logic                        o_stripe_valid,
  output logic [$clog2(N_STRIPE)-1:0] o_stripe_idx,
  output logic [$clog2(SEQ_LEN):0]    o_abs_end,
  output logic [13:0]                 o_max_score,
  output logic                        o_done,
  output logic                        o_timeout
);

  localparam int AW = $clog2(SEQ_LEN);
  localparam int KW = $clog2(N_STRIPE);
  localparam int RW = $clog2(N_PE);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STREAM, S_DRAIN, S_REPORT
  } state_t;

  state_t state, state_nx;

  logic [1:0]        mem_a [SEQ_LEN];
  logic [2*N_PE-1:0] mem_b [N_STRIPE];

  logic [KW-1:0] k;
  logic [AW-1:0] base;
  logic [AW-1:0] j;
  logic [AW-1:0] wd;
  logic          last_k;

  assign last_k = (k == KW'(N_STRIPE - 1));

  // B is kept one stripe per word so SETUP can fetch a whole stripe
  always_ff @(posedge i_clk) begin
    if (i_load_we && state == S_IDLE) begin
      if (i_load_sel)
        mem_b[i_load_addr[AW-1:RW]][{i_load_addr[RW-1:0], 1'b0} +: 2]
          <= i_load_data;
      else
        mem_a[i_load_addr] <= i_load_data;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (i_go) state_nx = S_SETUP;
      S_SETUP:  state_nx = S_STREAM;
      S_STREAM: begin
        if (i_stripe_end)
          state_nx = S_REPORT;
        else if (j == AW'(SEQ_LEN - 1))
          state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_stripe_end)
          state_nx = S_REPORT;
        else if (&wd)
          state_nx = S_IDLE;
      end
      S_REPORT: state_nx = last_k ? S_IDLE : S_SETUP;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign o_start        = (state == S_STREAM) && !i_stripe_end;
  assign o_A            = o_start ? mem_a[j] : 2'b00;
  assign o_busy         = (state != S_IDLE);
  assign o_stripe_valid = (state == S_REPORT);
  assign o_done         = (state == S_REPORT) && last_k;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      k            <= '0;
      base         <= '0;
      j            <= '0;
      wd           <= '0;
      o_B          <= '0;
      o_stripe_idx <= '0;
      o_abs_end    <= '0;
      o_max_score  <= '0;
      o_timeout    <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (i_go) begin
            k         <= '0;
            base      <= '0;
            o_timeout <= 1'b0;
          end
        end
        S_SETUP: begin
          o_B <= mem_b[k];
          j   <= base;
          wd  <= '0;
        end
        S_STREAM, S_DRAIN: begin
          // results are captured on the stripe_end cycle, shown in REPORT
          if (i_stripe_end) begin
            o_stripe_idx <= k;
            o_abs_end    <= {1'b0, i_end_position} + {1'b0, base};
            o_max_score  <= i_max_score_stripe;
            base         <= base + i_start_position;
          end else if (state == S_STREAM) begin
            j <= j + 1'b1;
          end else begin
            wd <= wd + 1'b1;
            if (&wd) o_timeout <= 1'b1;
          end
        end
        S_REPORT: if (!last_k) k <= k + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gene_stripe_feeder.sv
// Bench for gene_stripe_feeder: a stripe-level model predicts every output
// each cycle; a few literal checks pin the model to hand-computed values.
module tb_gene_stripe_feeder;
  localparam int N_PE = 64, SEQ_LEN = 1024, N_STRIPE = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, load_we, load_sel, go, stripe_end;
  logic [9:0] load_addr, start_pos, end_pos;
  logic [1:0] load_data;
  logic [13:0] max_score;
  logic [127:0] o_B;
  logic [1:0] o_A;
  logic o_start, o_busy, o_stripe_valid, o_done, o_timeout;
  logic [3:0] o_stripe_idx;
  logic [10:0] o_abs_end;
  logic [13:0] o_max_score;

  gene_stripe_feeder #(.N_PE(N_PE), .SEQ_LEN(SEQ_LEN), .N_STRIPE(N_STRIPE)) dut (
    .i_clk(clk), .i_rst(rst), .i_load_we(load_we), .i_load_sel(load_sel),
    .i_load_addr(load_addr), .i_load_data(load_data), .i_go(go),
    .i_stripe_end(stripe_end), .i_start_position(start_pos),
    .i_end_position(end_pos), .i_max_score_stripe(max_score),
    .o_B(o_B), .o_A(o_A), .o_start(o_start), .o_busy(o_busy),
    .o_stripe_valid(o_stripe_valid), .o_stripe_idx(o_stripe_idx),
    .o_abs_end(o_abs_end), .o_max_score(o_max_score), .o_done(o_done),
    .o_timeout(o_timeout)
  );

  int n_chk = 0, n_err = 0, start_cnt = 0, run_id = 0;
  bit chk_en = 1'b0;

  logic [127:0] e_B;
  logic [1:0] e_A;
  logic e_start, e_busy, e_valid, e_done, e_to;
  logic [3:0] e_idx;
  logic [10:0] e_abs;
  logic [13:0] e_score;

  logic [127:0] m_B;
  logic [3:0] m_idx;
  logic [10:0] m_abs;
  logic [13:0] m_score;
  logic m_to;

  logic [1:0] ma [SEQ_LEN];
  logic [1:0] mb [SEQ_LEN];
  int r_dly [N_STRIPE];
  int r_st [N_STRIPE];
  int r_en [N_STRIPE];
  int r_sc [N_STRIPE];

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (o_start === 1'b1) start_cnt++;
    if (chk_en) begin
      chk("o_B", o_B, e_B);
      chk("o_A", o_A, e_A);
      chk("o_start", o_start, e_start);
      chk("o_busy", o_busy, e_busy);
      chk("o_stripe_valid", o_stripe_valid, e_valid);
      chk("o_stripe_idx", o_stripe_idx, e_idx);
      chk("o_abs_end", o_abs_end, e_abs);
      chk("o_max_score", o_max_score, e_score);
      chk("o_done", o_done, e_done);
      chk("o_timeout", o_timeout, e_to);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic void idle_inputs();
    rst = 1'b0; load_we = 1'b0; load_sel = 1'b0;
    load_addr = '0; load_data = '0; go = 1'b0; stripe_end = 1'b0;
    start_pos = 10'($urandom);
    end_pos = 10'($urandom);
    max_score = 14'($urandom);
  endfunction

  function automatic void exp_hold(bit busy);
    e_B = m_B; e_idx = m_idx; e_abs = m_abs; e_score = m_score; e_to = m_to;
    e_busy = busy; e_start = 1'b0; e_A = 2'b00; e_valid = 1'b0; e_done = 1'b0;
  endfunction

  function automatic logic [127:0] brow(int k);
    logic [127:0] r;
    for (int p = 0; p < N_PE; p++) r[2*p +: 2] = mb[k*N_PE + p];
    return r;
  endfunction

  function automatic void clear_model();
    m_B = '0; m_idx = '0; m_abs = '0; m_score = '0; m_to = 1'b0;
  endfunction

  task automatic run(input int rst_k, input int rst_t);
    int b;
    int lim;
    tick(); idle_inputs(); go = 1'b1; stripe_end = 1'b1; exp_hold(1'b0);
    m_to = 1'b0;
    b = 0;
    for (int k = 0; k < N_STRIPE; k++) begin
      tick(); idle_inputs(); go = 1'b1; stripe_end = 1'b1; exp_hold(1'b1);
      start_cnt = 0;
      m_B = brow(k);
      lim = SEQ_LEN - b;
      for (int t = 0; ; t++) begin
        tick(); idle_inputs(); exp_hold(1'b1);
        if (t == r_dly[k]) begin
          stripe_end = 1'b1;
          start_pos = 10'(r_st[k]);
          end_pos = 10'(r_en[k]);
          max_score = 14'(r_sc[k]);
          m_idx = 4'(k);
          m_abs = 11'(r_en[k] + b);
          m_score = 14'(r_sc[k]);
          b = (b + r_st[k]) % SEQ_LEN;
          if (run_id == 1 && k == 3) begin
            settle(); chk("zero_symbol_stripe_start", o_start, 0);
          end
          break;
        end
        if (t < lim) begin
          e_start = 1'b1;
          e_A = ma[b + t];
        end else if (t == lim + SEQ_LEN) begin
          m_to = 1'b1;
          exp_hold(1'b0);
          return;
        end
        if (t == 1) go = 1'b1;
        if (run_id == 1 && k == 0 && t == 2) begin
          load_we = 1'b1; load_sel = 1'b0; load_addr = 10'd10; load_data = ~ma[10];
        end
        if (run_id == 1 && k == 0 && t == 3) begin
          load_we = 1'b1; load_sel = 1'b1; load_addr = 10'd70; load_data = ~mb[70];
        end
        if (k == rst_k && t == rst_t) begin
          rst = 1'b1;
          tick(); idle_inputs(); clear_model(); exp_hold(1'b0);
          settle();
          chk("reset_mid_B", o_B, 0);
          chk("reset_mid_abs_end", o_abs_end, 0);
          chk("reset_mid_busy", o_busy, 0);
          return;
        end
        if (t == 0 && (run_id == 1 || run_id == 3) && k == 0) begin
          settle();
          chk("B_pattern", o_B, {16{8'h1B}});
          chk("first_A", o_A, 0);
        end
        if (t == 0 && run_id == 1 && k == 1) begin
          settle(); chk("stripe1_first_A", o_A, 1);
        end
        if (t == 0 && run_id == 1 && k == 4) begin
          settle(); chk("wrapped_base_A", o_A, 2);
        end
      end
      tick(); idle_inputs(); exp_hold(1'b1);
      e_valid = 1'b1;
      e_done = (k == N_STRIPE - 1);
      if (run_id == 1) begin
        if (k == 0) begin
          settle();
          chk("stripe0_abs_end", o_abs_end, 900);
          chk("stripe0_score", o_max_score, 300);
          chk("stripe0_start_count", start_cnt, 1024);
        end else if (k == 2) begin
          settle(); chk("abs_end_11bit", o_abs_end, 2000);
        end else if (k == N_STRIPE - 1) begin
          settle();
          chk("last_done", o_done, 1);
          chk("last_idx", o_stripe_idx, 15);
        end
      end
    end
    tick(); idle_inputs(); exp_hold(1'b0);
    if (run_id == 1) begin
      settle(); chk("busy_after_done", o_busy, 0);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    clear_model();
    tick(); idle_inputs(); rst = 1'b1; exp_hold(1'b0);
    chk_en = 1'b1;
    settle();
    chk("reset_busy", o_busy, 0);
    chk("reset_B", o_B, 0);
    tick(); idle_inputs(); exp_hold(1'b0);

    for (int i = 0; i < 2*SEQ_LEN; i++) begin
      int a;
      a = i % SEQ_LEN;
      tick(); idle_inputs(); exp_hold(1'b0);
      stripe_end = (i % 2 == 1);
      load_we = 1'b1;
      load_sel = (i >= SEQ_LEN);
      load_addr = 10'(a);
      load_data = load_sel ? 2'(3 - a % 4) : 2'(a % 4);
      if (load_sel) mb[a] = load_data;
      else ma[a] = load_data;
    end

    for (int k = 0; k < N_STRIPE; k++) begin
      r_dly[k] = 3 + k % 5;
      r_st[k] = (k * 123) % SEQ_LEN;
      r_en[k] = (k * 77) % SEQ_LEN;
      r_sc[k] = (k * 1111) % 16384;
    end
    r_dly[0] = 1098; r_st[0] = 5;   r_en[0] = 900;  r_sc[0] = 300;
    r_dly[1] = 20;   r_st[1] = 995; r_en[1] = 10;   r_sc[1] = 1;
    r_dly[2] = 30;   r_st[2] = 30;  r_en[2] = 1000; r_sc[2] = 16383;
    r_dly[3] = 0;    r_st[3] = 0;   r_en[3] = 7;    r_sc[3] = 0;
    run_id = 1;
    run(-1, -1);

    for (int k = 0; k < N_STRIPE; k++) r_dly[k] = 6;
    run_id = 2;
    run(7, 5);

    for (int k = 0; k < N_STRIPE; k++) r_dly[k] = 2 + k % 3;
    run_id = 3;
    run(-1, -1);

    r_dly[0] = -1;
    run_id = 4;
    run(-1, -1);
    settle();
    chk("timeout_set", o_timeout, 1);
    chk("timeout_no_done", o_done, 0);
    chk("timeout_idle", o_busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); idle_inputs(); stripe_end = 1'b1; exp_hold(1'b0);
    end

    for (int k = 0; k < N_STRIPE; k++) r_dly[k] = k % 4;
    run_id = 5;
    run(-1, -1);

    tick(); idle_inputs(); exp_hold(1'b0);
    settle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
